fram_sram_responder: RTL and testbench
======================================

# fram_sram_responder

Synthesizable responder for the FRAM parallel bus. It emulates a 16-bit asynchronous FRAM/SRAM device with byte lanes, and sits on the device side of the bus opposite the FRAM controller in the simulation platform. It samples the chip-select, output-enable, write-enable and byte-lane strobes on `sys_clk` and commits writes to an internal word array. It returns read data on `fram_data_in` in time for the controller's read sample, and keeps access counters and a sticky protocol-error flag for diagnostics.

## Interface
- `MEM_AW`, default 12: internal array address width; depth is 2^MEM_AW 16-bit words.
- `sys_clk` in 1: single clock for all logic.
- `glbl_rst` in 1: reset, synchronous, active-high.
- `fram_addr` in 16: word address from the controller; only `[MEM_AW-1:0]` is used.
- `fram_data` in 16: write data from the controller.
- `fram_data_en` in 1: controller data-drive enable; informational only, not used for decoding.
- `fram_cen` in 1: chip enable, active-low.
- `fram_oen` in 1: output enable, active-low.
- `fram_wen` in 1: write enable, active-low.
- `fram_lbn` in 1: low-byte lane enable `[7:0]`, active-low.
- `fram_ubn` in 1: high-byte lane enable `[15:8]`, active-low.
- `fram_data_in` out 16: read data returned to the controller.
- `wr_cnt` out 16: committed write count.
- `rd_cnt` out 16: read access count.
- `err_clr` in 1: clears `err_flag`.
- `err_flag` out 1: sticky protocol error.

## Operation
- Input stage: every bus input is registered once (s_*). All decoding uses the registered copies.
- Decoded conditions:
  - `wr_act` = !s_cen & !s_wen.
  - `rd_act` = !s_cen & !s_oen & s_wen.
  - `err_cond` = !s_cen & !s_oen & !s_wen.
- Write capture:
  - In every cycle with `wr_act`, the capture registers load s_addr, s_data, s_lbn and s_ubn. The last-sampled values win, giving SRAM semantics (data latched at the trailing edge of WE).
  - A `wr_pend` flag sets on the first `wr_act` cycle.
- Write commit:
  - Occurs in the first cycle after `wr_act` falls, whether because s_wen or s_cen rose.
  - The lbn lane writes `[7:0]` and the ubn lane writes `[15:8]`; a disabled lane keeps its old byte.
  - `wr_cnt` increments only if at least one lane is enabled.
  - `wr_pend` clears at commit.
- Read:
  - In each cycle with `rd_act`, the next `fram_data_in` = mem[s_addr[MEM_AW-1:0]], with disabled-lane bytes forced to 8'h00.
  - In any cycle without `rd_act`, the next `fram_data_in` = 16'h0000.
- Read count: `rd_cnt` increments once per access, on the first `rd_act` cycle after a cycle without it. A continuous low period counts as one access even if the address changes during it.
- Error handling:
  - `err_cond` sets `err_flag`. It stays set until an `err_clr` cycle; if set and clear coincide, set wins.
  - During `err_cond` the cycle is treated as a write (wr_act); `fram_data_in` = 16'h0000.
- Address wrap: addresses at or above 2^MEM_AW alias modulo the depth. No error is raised.
- Counter wrap: both counters wrap 16'hFFFF -> 16'h0000.
- Write-then-read to the same address: the committed data is visible to any read whose `rd_act` cycle follows the commit cycle.
  - Commit happens before the array read in the same cycle, so read-after-write is bypassed.
- State machine, controlling write capture and commit:
  - IDLE -> CAPT on `wr_act`.
  - CAPT stays while `wr_act`; CAPT -> COMMIT when `wr_act` falls.
  - COMMIT -> CAPT if `wr_act` is already asserted again, otherwise COMMIT -> IDLE.

## Timing
- Reset values, all cleared in the first clock edge with `glbl_rst` high:
  - `fram_data_in` = 0, `wr_cnt` = 0, `rd_cnt` = 0, `err_flag` = 0.
  - FSM = IDLE, `wr_pend` = 0, input registers = inactive (strobes 1, addr/data 0).
  - Array contents are not cleared.
- Reset asserted mid-write: the pending write is discarded and nothing is committed.
- Read latency: pin pattern at edge N -> registered at N+1 -> `fram_data_in` valid after edge N+2.
  - For the controller's read sequence (oen observed low for 4 cycles, sample in the third), data is valid at the sample.
- Write commit: the array is updated at edge N+2, where N is the edge at which the pins first show wen or cen high. `wr_cnt` updates at the same edge.
- `rd_cnt` updates at edge N+2 after the first low-oen pin edge N.
- Back-to-back accesses separated by a single idle pin cycle are fully supported.

## Test plan
- Reset, then read addr 0x0005 with both lanes enabled after a prior write of 0xA55A -> `fram_data_in` = 0xA55A at the controller sample; `rd_cnt` = 1.
- Write 0x1234 to addr 0x0010 with ubn=1, lbn=0 over prior 0xFFFF, then read -> 0xFF34; `wr_cnt` = 1.
- Write 0xBEEF to 0x0001 and 0xCAFE to 0x0001 + 2^MEM_AW, then read 0x0001 -> 0xCAFE (alias).
- Assert cen=oen=wen=0 for one cycle -> `err_flag` = 1 and `fram_data_in` = 0. Hold `err_clr` in the same cycle as a new error -> flag stays 1. `err_clr` alone -> 0.
- Preload `wr_cnt` to 0xFFFF via 65535 writes, or force it, then do one more write -> 0x0000.
- Assert `glbl_rst` while wen is low -> no array change, `wr_cnt` = 0, all outputs 0 the next cycle.

Source files
------------

// File: rtl/fram_sram_responder.sv
// rtl/fram_sram_responder.sv - device-side responder emulating a 16-bit byte-laned async FRAM/SRAM
module fram_sram_responder #(
    parameter int MEM_AW = 12
) (
    input  logic        sys_clk,
    input  logic        glbl_rst,
    input  logic [15:0] fram_addr,
    input  logic [15:0] fram_data,
    input  logic        fram_data_en,
    input  logic        fram_cen,
    input  logic        fram_oen,
    input  logic        fram_wen,
    input  logic        fram_lbn,
    input  logic        fram_ubn,
    output logic [15:0] fram_data_in,
    output logic [15:0] wr_cnt,
    output logic [15:0] rd_cnt,
    input  logic        err_clr,
    output logic        err_flag
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPT,
        ST_COMMIT
    } state_t;

    state_t              state;
    logic [MEM_AW-1:0]   s_addr;
    logic [15:0]         s_data;
    logic                s_cen;
    logic                s_oen;
    logic                s_wen;
    logic                s_lbn;
    logic                s_ubn;

    logic [MEM_AW-1:0]   cap_addr;
    logic [15:0]         cap_data;
    logic                cap_lbn;
    logic                cap_ubn;
    logic                wr_pend;
    logic                rd_prev;

    logic [15:0]         mem [2**MEM_AW];

    logic                wr_act;
    logic                rd_act;
    logic                err_cond;
    logic                commit;
    logic                lanes_on;
    logic [15:0]         old_word;
    logic [15:0]         new_word;
    logic [15:0]         rd_word;

    // Upper address bits and the data-drive enable carry no meaning for this device.
    logic                unused_bits;
    assign unused_bits = &{1'b0, fram_data_en, fram_addr[15:MEM_AW]};

    always_comb begin
        wr_act   = !s_cen && !s_wen;
        rd_act   = !s_cen && !s_oen && s_wen;
        err_cond = !s_cen && !s_oen && !s_wen;
        commit   = (state == ST_CAPT) && !wr_act && wr_pend;
        lanes_on = !cap_lbn || !cap_ubn;
        old_word = mem[cap_addr];
        new_word = {cap_ubn ? old_word[15:8] : cap_data[15:8],
                    cap_lbn ? old_word[7:0]  : cap_data[7:0]};
        // A read sampled in the commit cycle sees the word being committed.
        if (commit && lanes_on && (s_addr == cap_addr)) begin
            rd_word = new_word;
        end else begin
            rd_word = mem[s_addr];
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!glbl_rst && commit && lanes_on) begin
            mem[cap_addr] <= new_word;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (glbl_rst) begin
            s_addr       <= '0;
            s_data       <= '0;
            s_cen        <= 1'b1;
            s_oen        <= 1'b1;
            s_wen        <= 1'b1;
            s_lbn        <= 1'b1;
            s_ubn        <= 1'b1;
            cap_addr     <= '0;
            cap_data     <= '0;
            cap_lbn      <= 1'b1;
            cap_ubn      <= 1'b1;
            wr_pend      <= 1'b0;
            rd_prev      <= 1'b0;
            state        <= ST_IDLE;
            fram_data_in <= '0;
            wr_cnt       <= '0;
            rd_cnt       <= '0;
            err_flag     <= 1'b0;
        end else begin
            s_addr <= fram_addr[MEM_AW-1:0];
            s_data <= fram_data;
            s_cen  <= fram_cen;
            s_oen  <= fram_oen;
            s_wen  <= fram_wen;
            s_lbn  <= fram_lbn;
            s_ubn  <= fram_ubn;

            // Last-sampled values win: data is effectively latched at the trailing WE edge.
            if (wr_act) begin
                cap_addr <= s_addr;
                cap_data <= s_data;
                cap_lbn  <= s_lbn;
                cap_ubn  <= s_ubn;
                wr_pend  <= 1'b1;
            end else if (commit) begin
                wr_pend  <= 1'b0;
            end

            if (commit && lanes_on) begin
                wr_cnt <= wr_cnt + 16'd1;
            end

            case (state)
                ST_IDLE:   state <= wr_act ? ST_CAPT : ST_IDLE;
                ST_CAPT:   state <= wr_act ? ST_CAPT : ST_COMMIT;
                ST_COMMIT: state <= wr_act ? ST_CAPT : ST_IDLE;
                default:   state <= ST_IDLE;
            endcase

            if (rd_act) begin
                fram_data_in <= {s_ubn ? 8'h00 : rd_word[15:8],
                                 s_lbn ? 8'h00 : rd_word[7:0]};
            end else begin
                fram_data_in <= 16'h0000;
            end

            rd_prev <= rd_act;
            if (rd_act && !rd_prev) begin
                rd_cnt <= rd_cnt + 16'd1;
            end

            if (err_cond) begin
                err_flag <= 1'b1;
            end else if (err_clr) begin
                err_flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fram_sram_responder.sv
// tb/tb_fram_sram_responder.sv - table-driven bench with read-data scoreboard for fram_sram_responder
module tb_fram_sram_responder;

    logic        sys_clk = 1'b0;
    logic        glbl_rst;
    logic [15:0] fram_addr;
    logic [15:0] fram_data;
    logic        fram_data_en;
    logic        fram_cen;
    logic        fram_oen;
    logic        fram_wen;
    logic        fram_lbn;
    logic        fram_ubn;
    logic [15:0] fram_data_in;
    logic [15:0] wr_cnt;
    logic [15:0] rd_cnt;
    logic        err_clr;
    logic        err_flag;

    fram_sram_responder #(.MEM_AW(12)) dut (
        .sys_clk      (sys_clk),
        .glbl_rst     (glbl_rst),
        .fram_addr    (fram_addr),
        .fram_data    (fram_data),
        .fram_data_en (fram_data_en),
        .fram_cen     (fram_cen),
        .fram_oen     (fram_oen),
        .fram_wen     (fram_wen),
        .fram_lbn     (fram_lbn),
        .fram_ubn     (fram_ubn),
        .fram_data_in (fram_data_in),
        .wr_cnt       (wr_cnt),
        .rd_cnt       (rd_cnt),
        .err_clr      (err_clr),
        .err_flag     (err_flag)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [15:0] waddr;
        logic [15:0] wdata;
        logic        wlbn;
        logic        wubn;
        logic [15:0] raddr;
        logic        rlbn;
        logic        rubn;
        logic [15:0] exp;
    } vec_t;

    vec_t        vecs [8];
    logic [15:0] exp_q [$];
    int          checks = 0;
    int          failures = 0;
    logic [15:0] wcnt_m = 16'd0;
    logic [15:0] rcnt_m = 16'd0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%04h required=%04h", name, act, req);
        end
    endtask

    task automatic pins_idle();
        fram_cen = 1'b1;
        fram_oen = 1'b1;
        fram_wen = 1'b1;
        fram_lbn = 1'b1;
        fram_ubn = 1'b1;
        fram_data_en = 1'b0;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d,
                             input logic lbn, input logic ubn, input int cycles);
        @(posedge sys_clk); #1;
        fram_addr = a; fram_data = d; fram_data_en = 1'b1;
        fram_lbn = lbn; fram_ubn = ubn; fram_cen = 1'b0; fram_wen = 1'b0; fram_oen = 1'b1;
        repeat (cycles) @(posedge sys_clk);
        #1 pins_idle();
    endtask

    // Controller-style read: oen low for four cycles, data sampled in the third.
    task automatic bus_read(input logic [15:0] a, input logic lbn, input logic ubn,
                            input logic [15:0] e);
        logic [15:0] want;
        @(posedge sys_clk); #1;
        fram_addr = a; fram_lbn = lbn; fram_ubn = ubn;
        fram_cen = 1'b0; fram_oen = 1'b0; fram_wen = 1'b1;
        exp_q.push_back(e);
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        want = exp_q.pop_front();
        check("read_data", fram_data_in, want);
        repeat (2) @(posedge sys_clk);
        #1 pins_idle();
    endtask

    initial begin
        vecs[0] = '{16'h0005, 16'hA55A, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0, 16'hA55A};
        vecs[1] = '{16'h0010, 16'hFFFF, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0, 16'hFFFF};
        vecs[2] = '{16'h0010, 16'h1234, 1'b0, 1'b1, 16'h0010, 1'b0, 1'b0, 16'hFF34};
        vecs[3] = '{16'h0010, 16'hABCD, 1'b1, 1'b0, 16'h0010, 1'b1, 1'b0, 16'hAB00};
        vecs[4] = '{16'h0001, 16'hBEEF, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0, 16'hBEEF};
        vecs[5] = '{16'h1001, 16'hCAFE, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0, 16'hCAFE};
        vecs[6] = '{16'h0020, 16'h5555, 1'b0, 1'b0, 16'h0020, 1'b0, 1'b1, 16'h0055};
        vecs[7] = '{16'h0020, 16'h0000, 1'b1, 1'b1, 16'h0020, 1'b0, 1'b0, 16'h5555};

        pins_idle();
        fram_addr = 16'h0000; fram_data = 16'h0000; err_clr = 1'b0;
        glbl_rst = 1'b1;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        check("rst_data_in", fram_data_in, 16'h0000);
        check("rst_wr_cnt", wr_cnt, 16'h0000);
        check("rst_rd_cnt", rd_cnt, 16'h0000);
        check("rst_err_flag", {15'd0, err_flag}, 16'h0000);
        @(posedge sys_clk); #1 glbl_rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            bus_write(vecs[i].waddr, vecs[i].wdata, vecs[i].wlbn, vecs[i].wubn, 2);
            if (!vecs[i].wlbn || !vecs[i].wubn) wcnt_m++;
            bus_read(vecs[i].raddr, vecs[i].rlbn, vecs[i].rubn, vecs[i].exp);
            rcnt_m++;
            repeat (2) @(posedge sys_clk);
            @(negedge sys_clk);
            check("idle_data_in", fram_data_in, 16'h0000);
            check("vec_wr_cnt", wr_cnt, wcnt_m);
            check("vec_rd_cnt", rd_cnt, rcnt_m);
        end

        // Data changes while WE is low: the last value must be the one stored.
        @(posedge sys_clk); #1;
        fram_addr = 16'h0050; fram_data = 16'h1111; fram_lbn = 1'b0; fram_ubn = 1'b0;
        fram_cen = 1'b0; fram_wen = 1'b0;
        @(posedge sys_clk); #1 fram_data = 16'h2222;
        @(posedge sys_clk); #1 pins_idle();
        wcnt_m++;
        bus_read(16'h0050, 1'b0, 1'b0, 16'h2222);
        rcnt_m++;

        // WE rises and OE falls on the same pin cycle: read must see the committed word.
        @(posedge sys_clk); #1;
        fram_addr = 16'h0040; fram_data = 16'h6789; fram_lbn = 1'b0; fram_ubn = 1'b0;
        fram_cen = 1'b0; fram_wen = 1'b0;
        @(posedge sys_clk); #1 fram_wen = 1'b1; fram_oen = 1'b0;
        exp_q.push_back(16'h6789);
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        check("bypass_read", fram_data_in, exp_q.pop_front());
        repeat (2) @(posedge sys_clk);
        #1 pins_idle();
        wcnt_m++; rcnt_m++;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        check("bypass_wr_cnt", wr_cnt, wcnt_m);
        check("bypass_rd_cnt", rd_cnt, rcnt_m);

        // Protocol error: cen, oen, wen all low for one cycle.
        @(posedge sys_clk); #1;
        fram_addr = 16'h0030; fram_data = 16'h7777; fram_lbn = 1'b0; fram_ubn = 1'b0;
        fram_cen = 1'b0; fram_oen = 1'b0; fram_wen = 1'b0;
        @(posedge sys_clk); #1 pins_idle();
        @(posedge sys_clk);
        @(negedge sys_clk);
        check("err_set", {15'd0, err_flag}, 16'h0001);
        check("err_data_in", fram_data_in, 16'h0000);
        @(posedge sys_clk); #1;
        fram_cen = 1'b0; fram_oen = 1'b0; fram_wen = 1'b0; fram_lbn = 1'b0; fram_ubn = 1'b0;
        @(posedge sys_clk); #1 pins_idle(); err_clr = 1'b1;
        @(posedge sys_clk); #1 err_clr = 1'b0;
        @(negedge sys_clk);
        check("err_set_wins", {15'd0, err_flag}, 16'h0001);
        @(posedge sys_clk); #1 err_clr = 1'b1;
        @(posedge sys_clk); #1 err_clr = 1'b0;
        @(negedge sys_clk);
        check("err_clr", {15'd0, err_flag}, 16'h0000);
        wcnt_m = wcnt_m + 16'd2;
        bus_read(16'h0030, 1'b0, 1'b0, 16'h7777);
        rcnt_m++;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        check("err_wr_cnt", wr_cnt, wcnt_m);

        // Counter wrap.
        @(posedge sys_clk); #1 force dut.wr_cnt = 16'hFFFF;
        @(posedge sys_clk); #1 release dut.wr_cnt;
        bus_write(16'h0060, 16'h0F0F, 1'b0, 1'b0, 1);
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        check("wr_cnt_wrap", wr_cnt, 16'h0000);

        // Reset during a write: nothing may be committed.
        @(posedge sys_clk); #1;
        fram_addr = 16'h0005; fram_data = 16'h0000; fram_lbn = 1'b0; fram_ubn = 1'b0;
        fram_cen = 1'b0; fram_wen = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1 glbl_rst = 1'b1;
        @(posedge sys_clk); #1 pins_idle();
        @(posedge sys_clk); #1 glbl_rst = 1'b0;
        @(negedge sys_clk);
        check("midrst_wr_cnt", wr_cnt, 16'h0000);
        check("midrst_rd_cnt", rd_cnt, 16'h0000);
        check("midrst_data_in", fram_data_in, 16'h0000);
        check("midrst_err_flag", {15'd0, err_flag}, 16'h0000);
        bus_read(16'h0005, 1'b0, 1'b0, 16'hA55A);
        repeat (4) @(posedge sys_clk);
        @(negedge sys_clk);
        check("midrst_wr_cnt_after", wr_cnt, 16'h0000);
        check("midrst_rd_cnt_after", rd_cnt, 16'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
